// File: rtl/sdram_port_pkg.sv
// sdram_port_pkg: states and shared constants for the SDRAM bank-port client
package sdram_port_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_P1, WR_P2, DONE} state_t;
  // Fetch-to-data offset; the controller's data path samples write data this many cycles after fetch
  localparam int P2_DELAY = 2;
  function automatic logic burst_len_ok(input int n);
    return n == 1 || n == 2 || n == 4;
  endfunction
endpackage

// File: rtl/sdram_port_client.sv
// sdram_port_client: host req/ack bridge onto one bank port of the slot-based SDRAM controller
module sdram_port_client
  import sdram_port_pkg::*;
#(
  parameter int BURST_LEN = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int TMO_CYCLES = 1023,
  parameter int TMO_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [29:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_be,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] host_rd_data,
  output logic        host_rd_valid,
  output logic        host_rd_last,
  output logic        port_rden,
  output logic        port_wren,
  output logic [31:0] port_addr,
  input  logic        port_valid,
  input  logic        port_fetch,
  output logic [3:0]  port_wr_bena,
  output logic [31:0] port_wr_data,
  input  logic [31:0] ram_rd_data
);
  state_t state, next_state;
  logic [TMO_W-1:0] tmo;
  logic [2:0] beat;
  logic [3:0] be;
  logic err;
  logic accept, capture, expire, last_beat, tmo_hit;
  if (!burst_len_ok(BURST_LEN) || P2_DELAY != 2) begin : g_bad_cfg
    $error("sdram_port_client: unsupported BURST_LEN or P2_DELAY");
  end
  assign last_beat = beat == 3'(BURST_LEN - 1);
  assign tmo_hit = tmo == TMO_W'(TMO_CYCLES - 1);
  assign port_rden = state == RD_REQ;
  assign port_wren = state == WR_REQ;
  assign port_wr_bena = state == WR_P2 ? be : 4'b0000;
  assign host_ack = state == DONE || err;
  assign host_err = err;
  // A timeout acks from IDLE, so the still-held request is not re-accepted until the ack cycle is over
  always_comb begin
    next_state = state;
    accept = 1'b0;
    capture = 1'b0;
    expire = 1'b0;
    case (state)
      IDLE: begin
        accept = host_req && !err;
        next_state = accept ? (host_we ? WR_REQ : RD_REQ) : IDLE;
      end
      RD_REQ, RD_DATA: begin
        capture = port_valid;
        expire = state == RD_REQ && !port_valid && tmo_hit;
        next_state = capture ? (last_beat ? DONE : RD_DATA) : expire ? IDLE : state;
      end
      WR_REQ: begin
        expire = !port_fetch && tmo_hit;
        next_state = port_fetch ? WR_P1 : expire ? IDLE : WR_REQ;
      end
      WR_P1: next_state = WR_P2;
      WR_P2: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmo <= '0;
      beat <= '0;
      be <= '0;
      err <= 1'b0;
      port_addr <= '0;
      port_wr_data <= '0;
      host_rd_data <= '0;
      host_rd_valid <= 1'b0;
      host_rd_last <= 1'b0;
    end else begin
      state <= next_state;
      tmo <= (state == next_state && (state == RD_REQ || state == WR_REQ)) ? tmo + 1'b1 : '0;
      beat <= accept ? '0 : beat + 3'(capture);
      err <= expire;
      host_rd_valid <= capture;
      host_rd_last <= capture && last_beat;
      if (capture) host_rd_data <= ram_rd_data;
      if (accept) begin
        port_addr <= {host_addr, 2'b00} + BASE_ADDR;
        port_wr_data <= host_wdata;
        be <= host_be;
      end
    end
  end
endmodule
